y_change_dispatcher: RTL
========================

// Module: y_change_dispatcher
// PURPOSE
//  Upstream stage of the change-in-Y integration core. Buffers incoming change records
//  (row, col, complex delta real/img) in a small FIFO and issues them one at a time to
//  the core, waiting for the core's write-done edge before issuing the next record.
//  Flags batch completion (last record retired) and stalled-core timeouts.
// PARAMETERS
//  DEPTH        8     FIFO entries (power of 2)
//  IDX_W        16    row/col index width
//  DATA_W       24    width of each of real/img deltas (two's complement)
//  TIMEOUT_CYC  1024  max cycles in WAIT before timeout
// PORTS
//  clock        in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-high
//  in_valid     in   1        upstream record valid
//  in_ready     out  1        FIFO not full; accept = in_valid & in_ready
//  in_row       in   IDX_W    Y row index
//  in_col       in   IDX_W    Y column index
//  in_real      in   DATA_W   real delta
//  in_img       in   DATA_W   imaginary delta
//  in_last      in   1        last record of batch
//  out_start    out  1        one-cycle pulse: payload valid, core begins update
//  out_row      out  IDX_W    registered payload, held until next out_start
//  out_col      out  IDX_W
//  out_real     out  DATA_W
//  out_img      out  DATA_W
//  write_done   in   1        core done; level or pulse, only rising edge counts
//  busy         out  1        state != IDLE or FIFO non-empty
//  batch_done   out  1        one-cycle pulse when a last-flagged record retires
//  disp_count   out  16       records retired since reset, wraps 0xFFFF->0
//  timeout_err  out  1        sticky; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; FIFO emptied; state IDLE; done edge reg = 0.
//    Reset mid-WAIT discards in-flight and queued records; no batch_done.
//  - in_ready = !full (registered-full, no pop bypass); push into full FIFO impossible.
//  - Edge detect: wd_q <= write_done each cycle; rise = write_done & !wd_q.
//  - FSM: IDLE -> ISSUE when FIFO non-empty.
//    ISSUE (1 cycle): out_start=1, payload regs loaded from head, pop -> WAIT.
//    WAIT: timer counts from 0. On rise: retire, disp_count+1, batch_done if last
//    -> ISSUE if FIFO non-empty (back-to-back), else IDLE.
//    If timer==TIMEOUT_CYC-1 without rise: timeout_err<=1, record retired without
//    disp_count increment (batch_done still fires if last) -> ISSUE/IDLE as above.
//  - A rise in ISSUE or IDLE is ignored (core needs >=1 cycle); a level held high
//    across records retires only one record.
//  - Latency: record accepted at edge k into empty FIFO/IDLE -> out_start high after
//    edge k+2. Retire edge m with FIFO non-empty -> out_start high after edge m+1.
//  - Simultaneous push and pop allowed; count unchanged, full/empty updated correctly.
//  - Payload passes unmodified (no arithmetic); last flag travels with its record.
// CONFIGURATION
//  ZERO_SKIP_EN defined: head record with real==0 && img==0 is popped in IDLE/WAIT-exit
//    without out_start (1 cycle, counts nothing); if last=1, batch_done still pulses.
//  Undefined: zero records dispatched like any other.
// STRUCTURE
//  Package y_integ_pkg: IDX_W/DATA_W constants, change_rec_t {row,col,re,im,last},
//    disp_state_t {IDLE, ISSUE, WAIT}.
//  Sub-module change_fifo: sync FIFO of change_rec_t, DEPTH, full/empty, async reset.
// TESTING
//  1 Reset asserted mid-run -> out_start/batch_done/busy/disp_count/timeout_err=0,
//    in_ready=1.
//  2 Push {row=0x0003,col=0x0005,re=0x000100,im=0xFFFF00,last=1} -> out_start after 2
//    edges with identical payload; write_done rise 5 cycles later -> batch_done pulse,
//    disp_count=1.
//  3 Push 10 records, no write_done -> 1 issued, 8 queued, in_ready=0 on 10th;
//    pulse done x10 -> all issued in order, disp_count=10.
//  4 Hold write_done=1 for 20 cycles over 2 queued records -> only first retires;
//    drop then re-raise -> second retires.
//  5 Withhold write_done 1024 cycles -> timeout_err=1, next record issued,
//    disp_count unchanged.
//  6 ZERO_SKIP_EN: push {re=0,im=0,last=1} -> no out_start, batch_done pulses,
//    disp_count unchanged.

Source files
------------

// File: rtl/y_integ_pkg.sv
// ---------------------------------------------------------------------------
// y_integ_pkg
// Shared types for the change-in-Y integration front end.
//   IDX_W / DATA_W : widths of the row/col index and of each delta half.
//                    The record type is built from these, so they are the
//                    single place to change the datapath width.
//   change_rec_t   : one change record {row, col, re, im, last}.
//   disp_state_t   : dispatcher FSM states.
//   is_zero_delta  : true when both halves of the complex delta are zero.
// ---------------------------------------------------------------------------
package y_integ_pkg;

    localparam int IDX_W  = 16;
    localparam int DATA_W = 24;

    typedef struct packed {
        logic [IDX_W-1:0]  row;
        logic [IDX_W-1:0]  col;
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        logic              last;
    } change_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } disp_state_t;

    function automatic logic is_zero_delta(input change_rec_t rec);
        return (rec.re == '0) && (rec.im == '0);
    endfunction

endpackage

// File: rtl/y_change_dispatcher_fifo.sv
// ---------------------------------------------------------------------------
// change_fifo
// Synchronous FIFO of change_rec_t records with registered full/empty flags.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   push, push_rec : write request and record (ignored while full)
//   pop            : read request (ignored while empty)
//   head           : record at the read pointer (valid while !empty)
//   full, empty    : registered status flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module change_fifo
    import y_integ_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  change_rec_t push_rec,
    input  logic        pop,
    output change_rec_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    change_rec_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Guard both sides here so the dispatcher can never corrupt the queue.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage has no reset; only the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    // Flags are computed from the pre-update count so they are ready as
    // registers on the same edge the count changes. A simultaneous push and
    // pop leaves count and both flags untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + 1'b1;
                    full  <= (count == CNT_W'(DEPTH - 1));
                    empty <= 1'b0;
                end
                2'b01: begin
                    count <= count - 1'b1;
                    full  <= 1'b0;
                    empty <= (count == CNT_W'(1));
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/y_change_dispatcher.sv
// ---------------------------------------------------------------------------
// y_change_dispatcher
// Upstream stage of the change-in-Y integration core. Queues change records
// and hands them to the core one at a time, waiting for the rising edge of
// write_done before issuing the next one.
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready     : upstream handshake (accept = in_valid & in_ready)
//   in_row, in_col          : Y matrix index of the change
//   in_real, in_img         : complex delta, two's complement
//   in_last                 : record closes a batch
//   out_start               : one-cycle pulse, payload valid, core starts
//   out_row/col/real/img    : registered payload, held until next out_start
//   write_done              : core finished (only the rising edge counts)
//   busy                    : FSM not idle or records still queued
//   batch_done              : one-cycle pulse when a last-flagged record retires
//   disp_count              : records retired normally since reset (wraps)
//   timeout_err             : sticky, core failed to answer in TIMEOUT_CYC
// Optional feature macro: ZERO_SKIP_EN -- records whose delta is zero are
// dropped without being issued to the core (batch_done still honoured).
// ---------------------------------------------------------------------------
module y_change_dispatcher
    import y_integ_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_row,
    input  logic [IDX_W-1:0]  in_col,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_img,
    input  logic              in_last,
    output logic              out_start,
    output logic [IDX_W-1:0]  out_row,
    output logic [IDX_W-1:0]  out_col,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_img,
    input  logic              write_done,
    output logic              busy,
    output logic              batch_done,
    output logic [15:0]       disp_count,
    output logic              timeout_err
);

    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    disp_state_t        state;
    change_rec_t        in_rec;
    change_rec_t        head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               wd_q;
    logic               rise;
    logic               cur_last;
    logic [TIMER_W-1:0] timer;

    assign in_rec = '{row: in_row, col: in_col, re: in_real, im: in_img, last: in_last};

    change_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (in_valid),
        .push_rec(in_rec),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Ready is the registered full flag: a pop in the same cycle does not
    // open a slot early, which keeps in_ready free of combinational paths.
    assign in_ready = ~fifo_full;
    assign busy     = (state != IDLE) | ~fifo_empty;
    assign rise     = write_done & ~wd_q;

    // The head record leaves the queue when it is issued, or, with zero
    // skipping, when it is discarded as a no-op update.
    always_comb begin
        pop = 1'b0;
        if (state == ISSUE) begin
            pop = 1'b1;
        end
`ifdef ZERO_SKIP_EN
        if ((state == IDLE) && !fifo_empty && is_zero_delta(head)) begin
            pop = 1'b1;
        end
`endif
    end

    // Dispatcher FSM. The edge register samples write_done in every state so
    // that a level still high from the previous record, or a rise that lands
    // while we are idle or issuing, never retires the record now waiting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wd_q        <= 1'b0;
            out_start   <= 1'b0;
            out_row     <= '0;
            out_col     <= '0;
            out_real    <= '0;
            out_img     <= '0;
            cur_last    <= 1'b0;
            timer       <= '0;
            batch_done  <= 1'b0;
            disp_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_q       <= write_done;
            out_start  <= 1'b0;
            batch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
`ifdef ZERO_SKIP_EN
                        if (is_zero_delta(head)) begin
                            batch_done <= head.last;
                        end else begin
                            state <= ISSUE;
                        end
`else
                        state <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
`ifdef ZERO_SKIP_EN
                    // A zero record reached after a retire is dropped here;
                    // IDLE then looks at whatever follows it.
                    if (is_zero_delta(head)) begin
                        batch_done <= head.last;
                        state      <= IDLE;
                    end else begin
                        out_start <= 1'b1;
                        out_row   <= head.row;
                        out_col   <= head.col;
                        out_real  <= head.re;
                        out_img   <= head.im;
                        cur_last  <= head.last;
                        timer     <= '0;
                        state     <= WAIT;
                    end
`else
                    out_start <= 1'b1;
                    out_row   <= head.row;
                    out_col   <= head.col;
                    out_real  <= head.re;
                    out_img   <= head.im;
                    cur_last  <= head.last;
                    timer     <= '0;
                    state     <= WAIT;
`endif
                end
                WAIT: begin
                    // A timed-out record is still retired (and still closes
                    // its batch) but is not counted as dispatched.
                    if (rise || (timer == TIMER_W'(TIMEOUT_CYC - 1))) begin
                        if (rise) begin
                            disp_count <= disp_count + 16'd1;
                        end else begin
                            timeout_err <= 1'b1;
                        end
                        batch_done <= cur_last;
                        state      <= fifo_empty ? IDLE : ISSUE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
